// File: rtl/csr_exec_unit.sv
// -----------------------------------------------------------------------------
// csr_exec_unit
// Initiator side of the machine-mode CSR interface. Takes one decoded
// SYSTEM-opcode instruction (CSRRW/S/C, CSRRWI/SI/CI, ECALL, EBREAK, MRET)
// per start pulse, sequences it onto the CSR file's read / write / trap / ret
// strobes and reports completion with a one-cycle done pulse.
//
// Optional feature macro: CSR_EXEC_IRQ_EN
//   defined   : start with irq=1 and mie=1 is turned into an external-interrupt
//               trap (cause 11, take_external_interupt=1) instead of executing.
//   undefined : irq and mie are ignored, take_external_interupt stays 0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               instruction valid (accepted only while busy=0)
//   funct3, csr_field,
//   rs1_field, rd_field decoded instruction fields
//   rs1_val             rs1 register value
//   irq, mie            pending external interrupt / mstatus.MIE
//   busy                unit occupied
//   done                one-cycle completion pulse
//   exc, mret_done      qualifiers of done (trap taken / MRET executed)
//   rd_we, rd_addr,
//   rd_data             register write-back (old CSR value)
//   csr_addr, csr_wdata,
//   csr_write_type      CSR access address, operand, 01 write/10 set/11 clear
//   csr_read, csr_write CSR access strobes (never together)
//   csr_rdata,
//   csr_invalid         combinational read data / address-not-implemented
//   trap, trap_cause    trap strobe and cause code
//   take_external_interupt  interrupt flag for mcause[31]
//   csr_ret             MRET strobe to the CSR file
// All outputs are flops; the only combinational path is
// csr_rdata/csr_invalid into the next-state and rd_data capture.
// -----------------------------------------------------------------------------
module csr_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_field,
    input  logic [4:0]  rs1_field,
    input  logic [4:0]  rd_field,
    input  logic [31:0] rs1_val,
    input  logic        irq,
    input  logic        mie,
    output logic        busy,
    output logic        done,
    output logic        exc,
    output logic        mret_done,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_read,
    output logic        csr_write,
    output logic [1:0]  csr_write_type,
    input  logic [31:0] csr_rdata,
    input  logic        csr_invalid,
    output logic        trap,
    output logic [4:0]  trap_cause,
    output logic        take_external_interupt,
    output logic        csr_ret
);

    localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
    localparam logic [4:0] CAUSE_BREAK   = 5'd3;
    localparam logic [4:0] CAUSE_ECALL   = 5'd11;
    localparam logic [4:0] CAUSE_EXT_IRQ = 5'd11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_TRAP  = 3'd3,
        S_RET   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state_r;
    logic   need_wr_r;
    logic   irq_take_s;
    state_t start_state_s;
    logic   [4:0] start_cause_s;

    // First state of a freshly accepted instruction from its encoding.
    function automatic state_t decode_state(input logic [2:0] f3, input logic [11:0] csr);
        state_t ns;
        case (f3)
            3'b000: begin
                case (csr)
                    12'h000: ns = S_TRAP;
                    12'h001: ns = S_TRAP;
                    12'h302: ns = S_RET;
                    default: ns = S_TRAP;
                endcase
            end
            3'b100:  ns = S_TRAP;
            default: ns = S_READ;
        endcase
        return ns;
    endfunction

    // Trap cause for encodings that trap straight out of IDLE.
    function automatic logic [4:0] decode_cause(input logic [2:0] f3, input logic [11:0] csr);
        logic [4:0] c;
        if (f3 == 3'b000 && csr == 12'h000) begin
            c = CAUSE_ECALL;
        end else if (f3 == 3'b000 && csr == 12'h001) begin
            c = CAUSE_BREAK;
        end else begin
            c = CAUSE_ILLEGAL;
        end
        return c;
    endfunction

`ifdef CSR_EXEC_IRQ_EN
    // Interrupt is taken at instruction acceptance when globally enabled.
    always_comb begin
        irq_take_s = irq & mie;
    end
`else
    logic irq_unused_s;

    // Interrupt inputs are not part of this build.
    always_comb begin
        irq_take_s   = 1'b0;
        irq_unused_s = irq ^ mie;
    end
`endif

    // Decode of the incoming instruction, used only in IDLE.
    always_comb begin
        start_state_s = decode_state(funct3, csr_field);
        start_cause_s = decode_cause(funct3, csr_field);
    end

    // Sequencer: state and every output are registered together so that each
    // strobe is a clean decode of the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r                <= S_IDLE;
            need_wr_r              <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            exc                    <= 1'b0;
            mret_done              <= 1'b0;
            rd_we                  <= 1'b0;
            rd_addr                <= 5'd0;
            rd_data                <= 32'd0;
            csr_addr               <= 12'd0;
            csr_wdata              <= 32'd0;
            csr_read               <= 1'b0;
            csr_write              <= 1'b0;
            csr_write_type         <= 2'b00;
            trap                   <= 1'b0;
            trap_cause             <= 5'd0;
            take_external_interupt <= 1'b0;
            csr_ret                <= 1'b0;
        end else begin
            // Pulses default low; each state entry raises its own.
            done                   <= 1'b0;
            exc                    <= 1'b0;
            mret_done              <= 1'b0;
            rd_we                  <= 1'b0;
            csr_read               <= 1'b0;
            csr_write              <= 1'b0;
            trap                   <= 1'b0;
            take_external_interupt <= 1'b0;
            csr_ret                <= 1'b0;

            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        csr_addr       <= csr_field;
                        csr_wdata      <= funct3[2] ? {27'd0, rs1_field} : rs1_val;
                        csr_write_type <= funct3[1:0];
                        rd_addr        <= rd_field;
                        rd_data        <= 32'd0;
                        // RW forms always write; S/C forms only with a nonzero source.
                        need_wr_r      <= (funct3[1:0] == 2'b01) || (rs1_field != 5'd0);
                        if (irq_take_s) begin
                            state_r                <= S_TRAP;
                            trap                   <= 1'b1;
                            trap_cause             <= CAUSE_EXT_IRQ;
                            take_external_interupt <= 1'b1;
                            done                   <= 1'b1;
                            exc                    <= 1'b1;
                        end else begin
                            state_r <= start_state_s;
                            case (start_state_s)
                                S_READ: begin
                                    csr_read <= 1'b1;
                                end
                                S_RET: begin
                                    csr_ret   <= 1'b1;
                                    done      <= 1'b1;
                                    mret_done <= 1'b1;
                                end
                                S_TRAP: begin
                                    trap       <= 1'b1;
                                    trap_cause <= start_cause_s;
                                    done       <= 1'b1;
                                    exc        <= 1'b1;
                                end
                                default: begin
                                    state_r <= S_IDLE;
                                    busy    <= 1'b0;
                                end
                            endcase
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end

                S_READ: begin
                    rd_data <= csr_rdata;
                    // Writes to the 0b11 address block are read-only violations.
                    if (csr_invalid || (need_wr_r && csr_addr[11:10] == 2'b11)) begin
                        state_r    <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                        done       <= 1'b1;
                        exc        <= 1'b1;
                    end else if (need_wr_r) begin
                        state_r   <= S_WRITE;
                        csr_write <= 1'b1;
                    end else begin
                        state_r <= S_DONE;
                        done    <= 1'b1;
                        rd_we   <= (rd_addr != 5'd0);
                    end
                end

                S_WRITE: begin
                    state_r <= S_DONE;
                    done    <= 1'b1;
                    rd_we   <= (rd_addr != 5'd0);
                end

                S_TRAP, S_RET, S_DONE: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_exec_unit.sv
module tb_csr_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [11:0] csr_field;
    logic [4:0]  rs1_field;
    logic [4:0]  rd_field;
    logic [31:0] rs1_val;
    logic        irq;
    logic        mie;
    logic        busy, done, exc, mret_done, rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_read, csr_write;
    logic [1:0]  csr_write_type;
    logic [31:0] csr_rdata;
    logic        csr_invalid;
    logic        trap;
    logic [4:0]  trap_cause;
    logic        take_external_interupt;
    logic        csr_ret;

    int checks   = 0;
    int failures = 0;

`ifdef CSR_EXEC_IRQ_EN
    localparam bit IRQ_FEATURE = 1'b1;
`else
    localparam bit IRQ_FEATURE = 1'b0;
`endif

    always #5 clk = ~clk;

    csr_exec_unit dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .csr_field(csr_field), .rs1_field(rs1_field), .rd_field(rd_field),
        .rs1_val(rs1_val), .irq(irq), .mie(mie), .busy(busy), .done(done),
        .exc(exc), .mret_done(mret_done), .rd_we(rd_we), .rd_addr(rd_addr),
        .rd_data(rd_data), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_read(csr_read), .csr_write(csr_write),
        .csr_write_type(csr_write_type), .csr_rdata(csr_rdata),
        .csr_invalid(csr_invalid), .trap(trap), .trap_cause(trap_cause),
        .take_external_interupt(take_external_interupt), .csr_ret(csr_ret)
    );

    // Behavioural CSR file: a handful of implemented registers.
    logic [11:0] impl_addr [8] = '{12'h300, 12'h304, 12'h305, 12'h340,
                                   12'h341, 12'h342, 12'hF11, 12'hF14};
    logic [31:0] csr_mem [8];
    int          comb_ix;

    function automatic int csr_idx(input logic [11:0] a);
        for (int i = 0; i < 8; i++) begin
            if (impl_addr[i] == a) return i;
        end
        return -1;
    endfunction

    always_comb begin
        csr_rdata   = 32'h0;
        csr_invalid = 1'b1;
        comb_ix     = csr_idx(csr_addr);
        if (comb_ix >= 0) begin
            csr_rdata   = csr_mem[comb_ix];
            csr_invalid = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) csr_mem[i] <= 32'h0;
            csr_mem[0] <= 32'h0000_1800;
        end else if (csr_write && csr_idx(csr_addr) >= 0) begin
            case (csr_write_type)
                2'b01:   csr_mem[csr_idx(csr_addr)] <= csr_wdata;
                2'b10:   csr_mem[csr_idx(csr_addr)] <= csr_mem[csr_idx(csr_addr)] | csr_wdata;
                2'b11:   csr_mem[csr_idx(csr_addr)] <= csr_mem[csr_idx(csr_addr)] & ~csr_wdata;
                default: csr_mem[csr_idx(csr_addr)] <= csr_mem[csr_idx(csr_addr)];
            endcase
        end
    end

    // Issue one instruction, watch it to completion and score it against the
    // architectural outcome derived from the instruction and the CSR model.
    task automatic exec_and_score(input string nm, input logic [2:0] f3,
                                  input logic [11:0] ca, input logic [4:0] r1,
                                  input logic [4:0] rdf, input logic [31:0] rv,
                                  input logic ii, input logic mm, input logic hold);
        int ix, e_lat, lat, n_wr;
        logic e_trap, e_ret, e_read, e_wr, e_rdwe, e_ext, wants_write;
        logic [4:0] e_cause, o_cause, o_rdaddr;
        logic [31:0] e_old, e_wdata, e_new, o_wdata, o_rddata;
        logic [1:0] e_type, o_type;
        logic s_read, s_overlap, s_busy_bad, o_exc, o_mret, o_ret, o_trap, o_rdwe, o_ext;

        ix    = csr_idx(ca);
        e_old = (ix >= 0) ? csr_mem[ix] : 32'h0;
        e_trap = 1'b0; e_ret = 1'b0; e_read = 1'b0; e_wr = 1'b0; e_rdwe = 1'b0;
        e_ext = 1'b0; e_cause = 5'd0; e_lat = 1; e_wdata = 32'h0; e_type = 2'b00;
        e_new = e_old;
        if (IRQ_FEATURE && ii && mm) begin
            e_trap = 1'b1; e_cause = 5'd11; e_ext = 1'b1;
        end else if (f3 == 3'd0 && ca == 12'h000) begin
            e_trap = 1'b1; e_cause = 5'd11;
        end else if (f3 == 3'd0 && ca == 12'h001) begin
            e_trap = 1'b1; e_cause = 5'd3;
        end else if (f3 == 3'd0 && ca == 12'h302) begin
            e_ret = 1'b1;
        end else if (f3 == 3'd0 || f3 == 3'd4) begin
            e_trap = 1'b1; e_cause = 5'd2;
        end else begin
            e_read = 1'b1; e_lat = 2;
            wants_write = (f3[1:0] == 2'b01) || (r1 != 5'd0);
            if (ix < 0 || (wants_write && ca[11:10] == 2'b11)) begin
                e_trap = 1'b1; e_cause = 5'd2;
            end else begin
                e_rdwe = (rdf != 5'd0);
                if (wants_write) begin
                    e_wr = 1'b1; e_lat = 3; e_type = f3[1:0];
                    e_wdata = f3[2] ? {27'd0, r1} : rv;
                    if (e_type == 2'b01)      e_new = e_wdata;
                    else if (e_type == 2'b10) e_new = e_old | e_wdata;
                    else                      e_new = e_old & ~e_wdata;
                end
            end
        end

        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_before_start: busy=%0b expected 0", nm, busy);
        end
        start = 1'b1; funct3 = f3; csr_field = ca; rs1_field = r1; rd_field = rdf;
        rs1_val = rv; irq = ii; mie = mm;

        lat = -1; n_wr = 0; s_read = 1'b0; s_overlap = 1'b0; s_busy_bad = 1'b0;
        o_wdata = 32'h0; o_type = 2'b00; o_exc = 1'b0; o_mret = 1'b0; o_ret = 1'b0;
        o_trap = 1'b0; o_rdwe = 1'b0; o_ext = 1'b0; o_cause = 5'd0; o_rdaddr = 5'd0;
        o_rddata = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (hold) begin
                // Garbage start while busy must be ignored.
                start = 1'b1; funct3 = 3'd0; csr_field = 12'h001; rs1_field = 5'd7;
                rd_field = 5'd9; rs1_val = 32'h5555_AAAA;
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1) s_busy_bad = 1'b1;
            if (csr_read) s_read = 1'b1;
            if (csr_write) begin
                n_wr++; o_wdata = csr_wdata; o_type = csr_write_type;
            end
            if ((csr_read && csr_write) || (trap && csr_ret)) s_overlap = 1'b1;
            if (done) begin
                lat = c; o_exc = exc; o_mret = mret_done; o_ret = csr_ret; o_trap = trap;
                o_cause = trap_cause; o_ext = take_external_interupt; o_rdwe = rd_we;
                o_rdaddr = rd_addr; o_rddata = rd_data;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0; irq = 1'b0; mie = 1'b0;

        checks++;
        if (lat !== e_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", nm, lat, e_lat);
        end
        if (lat < 0) return;
        checks++;
        if ({o_trap, o_exc, o_ret, o_mret, o_ext} !== {e_trap, e_trap, e_ret, e_ret, e_ext}) begin
            failures++;
            $display("FAIL %s kind trap/exc/ret/mret/ext: got %b expected %b", nm,
                     {o_trap, o_exc, o_ret, o_mret, o_ext}, {e_trap, e_trap, e_ret, e_ret, e_ext});
        end
        if (e_trap) begin
            checks++;
            if (o_cause !== e_cause) begin
                failures++;
                $display("FAIL %s trap_cause: got %0d expected %0d", nm, o_cause, e_cause);
            end
        end
        checks++;
        if (o_rdwe !== e_rdwe) begin
            failures++;
            $display("FAIL %s rd_we: got %0b expected %0b", nm, o_rdwe, e_rdwe);
        end
        if (!e_trap && !e_ret) begin
            checks++;
            if (o_rddata !== e_old || o_rdaddr !== rdf) begin
                failures++;
                $display("FAIL %s rd_data/rd_addr: got %h/%0d expected %h/%0d", nm,
                         o_rddata, o_rdaddr, e_old, rdf);
            end
        end
        checks++;
        if (s_read !== e_read || n_wr !== (e_wr ? 1 : 0)) begin
            failures++;
            $display("FAIL %s accesses read/writes: got %0b/%0d expected %0b/%0d", nm,
                     s_read, n_wr, e_read, e_wr ? 1 : 0);
        end
        if (e_wr) begin
            checks++;
            if (o_wdata !== e_wdata || o_type !== e_type) begin
                failures++;
                $display("FAIL %s write wdata/type: got %h/%b expected %h/%b", nm,
                         o_wdata, o_type, e_wdata, e_type);
            end
        end
        checks++;
        if (s_overlap || s_busy_bad) begin
            failures++;
            $display("FAIL %s strobe_overlap/busy: got %0b/%0b expected 0/0", nm, s_overlap, s_busy_bad);
        end
        if (ix >= 0) begin
            checks++;
            if (csr_mem[ix] !== e_new) begin
                failures++;
                $display("FAIL %s csr_value: got %h expected %h", nm, csr_mem[ix], e_new);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, exc, mret_done, rd_we, rd_addr, rd_data, csr_addr, csr_wdata,
             csr_read, csr_write, csr_write_type, trap, trap_cause,
             take_external_interupt, csr_ret} !== 98'd0) begin
            failures++;
            $display("FAIL reset_outputs: got nonzero outputs expected all 0 (busy=%0b csr_addr=%h)",
                     busy, csr_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_plan_cases();
        exec_and_score("csrrw_340", 3'b001, 12'h340, 5'd1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        exec_and_score("csrrs_mstatus_ro", 3'b010, 12'h300, 5'd0, 5'd3, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        exec_and_score("csrrw_mstatus", 3'b001, 12'h300, 5'd2, 5'd0, 32'h0000_1888, 1'b0, 1'b0, 1'b0);
        exec_and_score("csrrci_mstatus", 3'b111, 12'h300, 5'd8, 5'd4, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        exec_and_score("csrrw_f11", 3'b001, 12'hF11, 5'd3, 5'd6, 32'h1111_0000, 1'b0, 1'b0, 1'b0);
        exec_and_score("csrrs_7c0", 3'b010, 12'h7C0, 5'd3, 5'd6, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        exec_and_score("ecall", 3'b000, 12'h000, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        exec_and_score("ebreak", 3'b000, 12'h001, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        exec_and_score("mret", 3'b000, 12'h302, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        exec_and_score("funct3_100", 3'b100, 12'h300, 5'd1, 5'd1, 32'h0, 1'b0, 1'b0, 1'b0);
        exec_and_score("irq_mie1", 3'b001, 12'h341, 5'd1, 5'd2, 32'hCAFE_0000, 1'b1, 1'b1, 1'b0);
        exec_and_score("irq_mie0", 3'b001, 12'h341, 5'd1, 5'd2, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0);
        exec_and_score("irq_over_ecall", 3'b000, 12'h000, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_busy_ignore();
        exec_and_score("hold_csrrs", 3'b010, 12'h304, 5'd4, 5'd7, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b1);
        exec_and_score("hold_csrrsi0", 3'b110, 12'h304, 5'd0, 5'd8, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        start = 1'b1; funct3 = 3'b001; csr_field = 12'h342; rs1_field = 5'd1;
        rd_field = 5'd1; rs1_val = 32'h7777_7777; irq = 1'b0; mie = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (csr_write !== 1'b1) begin
            failures++;
            $display("FAIL midreset_in_write: csr_write=%0b expected 1", csr_write);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, exc, mret_done, rd_we, rd_addr, rd_data, csr_addr, csr_wdata,
             csr_read, csr_write, csr_write_type, trap, trap_cause,
             take_external_interupt, csr_ret} !== 98'd0) begin
            failures++;
            $display("FAIL midreset_outputs: busy=%0b csr_write=%0b done=%0b expected all 0",
                     busy, csr_write, done);
        end
        rst = 1'b0;
        exec_and_score("after_midreset_ecall", 3'b000, 12'h000, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [11:0] pool [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'hF11, 12'hF14, 12'h7C0, 12'h000, 12'h001, 12'h302};
        logic [11:0] ca;
        logic [4:0]  r1, rdf;
        for (int n = 0; n < 80; n++) begin
            ca  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : pool[$urandom_range(0, 11)];
            r1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rdf = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            exec_and_score("random", 3'($urandom_range(0, 7)), ca, r1, rdf, $urandom,
                           1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0));
        end
    endtask

    task automatic test_back_to_back();
        exec_and_score("b2b_0", 3'b011, 12'h305, 5'd31, 5'd10, 32'h0, 1'b0, 1'b0, 1'b0);
        exec_and_score("b2b_1", 3'b101, 12'h305, 5'd17, 5'd11, 32'h0, 1'b0, 1'b0, 1'b0);
        exec_and_score("b2b_2", 3'b000, 12'h302, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        exec_and_score("b2b_3", 3'b010, 12'h305, 5'd0, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; funct3 = 3'd0; csr_field = 12'd0; rs1_field = 5'd0;
        rd_field = 5'd0; rs1_val = 32'd0; irq = 1'b0; mie = 1'b0;
        test_reset();
        test_plan_cases();
        test_busy_ignore();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
